// File: rtl/secuencia_pkg.sv
// -----------------------------------------------------------------------------
// secuencia_pkg
// Shared definitions for the successive-process sequence generator and its
// receive-side checker, so that both ends agree on sample width, step size
// and what "successor" means.
//   state_t  : checker FSM states (IDLE, SEARCH, LOCKED)
//   W_DEF    : default sample width
//   STEP_DEF : default increment between consecutive samples
//   succ()   : ref + step; the caller truncates to its sample width, which
//              gives the mod 2^W wrap-around
// -----------------------------------------------------------------------------
package secuencia_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LOCKED
    } state_t;

    localparam int unsigned W_DEF    = 4;
    localparam int unsigned STEP_DEF = 1;

    function automatic logic [31:0] succ(input logic [31:0] ref_v,
                                         input logic [31:0] step);
        return ref_v + step;
    endfunction

endpackage

// File: rtl/contador_saturante.sv
// -----------------------------------------------------------------------------
// contador_saturante
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : add one this cycle (ignored once saturated)
//   count : current count
// -----------------------------------------------------------------------------
module contador_saturante #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/verificador_secuencia.sv
// -----------------------------------------------------------------------------
// verificador_secuencia
// Integrity monitor for the successive-process stream. Every valid sample
// must equal the previous one plus STEP (mod 2^W). The checker acquires lock
// after LOCK_N consecutive successors, then flags and counts misses; LOSS_N
// consecutive misses drop it back to SEARCH.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   F_in        : sample, MSB is F_in[0]
//   valid       : F_in carries a new sample this cycle
//   locked      : FSM is in LOCKED
//   error       : one-cycle pulse per miss while LOCKED
//   expected    : value the next sample must take (ref + STEP)
//   match_count : saturating count of good samples while LOCKED
//   err_count   : saturating count of misses while LOCKED
// -----------------------------------------------------------------------------
module verificador_secuencia
    import secuencia_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned STEP   = STEP_DEF,
    parameter int unsigned LOCK_N = 3,
    parameter int unsigned LOSS_N = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:W-1]     F_in,
    input  logic             valid,
    output logic             locked,
    output logic             error,
    output logic [0:W-1]     expected,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W  = $clog2(LOCK_N + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_N + 1);

    state_t              state_q, state_d;
    logic [0:W-1]        ref_q, ref_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                error_q, error_d;
    logic                match_inc, err_inc;
    logic [0:W-1]        succ_v;
    logic                hit;
    logic [RUN_W-1:0]    run_inc;
    logic [MISS_W-1:0]   miss_inc;

    assign succ_v   = W'(succ(32'(ref_q), 32'(STEP)));
    assign hit      = (F_in == succ_v);
    assign run_inc  = run_q + RUN_W'(1);
    assign miss_inc = miss_q + MISS_W'(1);

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        run_d     = run_q;
        miss_d    = miss_q;
        error_d   = 1'b0;
        match_inc = 1'b0;
        err_inc   = 1'b0;
        if (valid) begin
            unique case (state_q)
                IDLE: begin
                    ref_d   = F_in;
                    run_d   = '0;
                    state_d = SEARCH;
                end
                SEARCH: begin
                    ref_d = F_in;
                    if (hit) begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(LOCK_N)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        ref_d     = F_in;
                        miss_d    = '0;
                        match_inc = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        err_inc = 1'b1;
                        if (miss_inc == MISS_W'(LOSS_N)) begin
                            // Lock lost: resync on the offending sample.
                            state_d = SEARCH;
                            ref_d   = F_in;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            // Flywheel: advance as if the sample had been right.
                            ref_d  = succ_v;
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ref_q   <= '0;
            run_q   <= '0;
            miss_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
            error_q <= error_d;
        end
    end

    contador_saturante #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_inc),
        .count (match_count)
    );

    contador_saturante #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (err_count)
    );

    assign locked   = (state_q == LOCKED);
    assign error    = error_q;
    assign expected = succ_v;

endmodule

// File: tb/tb_verificador_secuencia.sv
module tb_verificador_secuencia;

    logic       clk;
    logic       rst;
    logic [0:3] F_in;
    logic       valid;
    logic       locked;
    logic       error;
    logic [0:3] expected;
    logic [7:0] match_count;
    logic [7:0] err_count;

    int tests;
    int failures;

    verificador_secuencia #(
        .W      (4),
        .STEP   (1),
        .LOCK_N (3),
        .LOSS_N (2),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .F_in        (F_in),
        .valid       (valid),
        .locked      (locked),
        .error       (error),
        .expected    (expected),
        .match_count (match_count),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] f);
        rst   = r;
        valid = v;
        F_in  = f;
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic lk, input logic er,
                        input logic [3:0] ex, input logic [7:0] mc, input logic [7:0] ec);
        check({tag, ".locked"},   32'(locked),      32'(lk));
        check({tag, ".error"},    32'(error),       32'(er));
        check({tag, ".expected"}, 32'(expected),    32'(ex));
        check({tag, ".match"},    32'(match_count), 32'(mc));
        check({tag, ".errcnt"},   32'(err_count),   32'(ec));
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        valid    = 1'b0;
        F_in     = '0;

        // Reset state
        step(1, 0, 0);
        step(1, 0, 0);
        outs("reset", 0, 0, 4'd1, 8'd0, 8'd0);

        // Acquire lock on 0,1,2,3 then one match on 4
        step(0, 1, 0);  outs("acq0", 0, 0, 4'd1, 8'd0, 8'd0);
        step(0, 1, 1);  outs("acq1", 0, 0, 4'd2, 8'd0, 8'd0);
        step(0, 1, 2);  outs("acq2", 0, 0, 4'd3, 8'd0, 8'd0);
        step(0, 1, 3);  outs("acq3", 1, 0, 4'd4, 8'd0, 8'd0);
        step(0, 1, 4);  outs("acq4", 1, 0, 4'd5, 8'd1, 8'd0);

        // valid gaps are ignored
        step(0, 1, 5);  outs("gap5", 1, 0, 4'd6, 8'd2, 8'd0);
        step(0, 0, 9);  outs("gapA", 1, 0, 4'd6, 8'd2, 8'd0);
        step(0, 0, 2);  outs("gapB", 1, 0, 4'd6, 8'd2, 8'd0);
        step(0, 1, 6);  outs("gap6", 1, 0, 4'd7, 8'd3, 8'd0);

        // Single miss, flywheel keeps lock
        step(0, 1, 10); outs("miss1", 1, 1, 4'd8, 8'd3, 8'd1);
        step(0, 1, 8);  outs("fly8",  1, 0, 4'd9, 8'd4, 8'd1);

        // Two misses lose lock, resync on the second bad sample (15)
        step(0, 1, 12); outs("loss1", 1, 1, 4'd10, 8'd4, 8'd2);
        step(0, 1, 15); outs("loss2", 0, 1, 4'd0,  8'd4, 8'd3);
        step(0, 1, 0);  outs("rel0",  0, 0, 4'd1,  8'd4, 8'd3);
        step(0, 1, 1);  outs("rel1",  0, 0, 4'd2,  8'd4, 8'd3);
        step(0, 1, 2);  outs("rel2",  1, 0, 4'd3,  8'd4, 8'd3);

        // Run up to 13, then wrap 14,15,0,1
        for (int i = 3; i <= 13; i++) step(0, 1, 4'(i));
        outs("at13", 1, 0, 4'd14, 8'd15, 8'd3);
        step(0, 1, 14); outs("w14", 1, 0, 4'd15, 8'd16, 8'd3);
        step(0, 1, 15); outs("w15", 1, 0, 4'd0,  8'd17, 8'd3);
        step(0, 1, 0);  outs("w0",  1, 0, 4'd1,  8'd18, 8'd3);
        step(0, 1, 1);  outs("w1",  1, 0, 4'd2,  8'd19, 8'd3);

        // Mid-stream reset with valid high
        step(1, 1, 2);  outs("midrst", 0, 0, 4'd1, 8'd0, 8'd0);
        step(0, 1, 7);  outs("idle7",  0, 0, 4'd8, 8'd0, 8'd0);
        step(0, 1, 8);
        step(0, 1, 9);
        step(0, 1, 10); outs("relk10", 1, 0, 4'd11, 8'd0, 8'd0);

        // Saturate match_count at 255
        for (int i = 0; i < 260; i++) step(0, 1, 4'((11 + i) % 16));
        // last sample (11+259)%16 = 14
        outs("sat", 1, 0, 4'd15, 8'd255, 8'd0);
        step(0, 1, 3);  outs("satmiss", 1, 1, 4'd0, 8'd255, 8'd1);
        step(0, 1, 0);  outs("satok",   1, 0, 4'd1, 8'd255, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
